// File: rtl/param_fetch_pkg.sv
// Shared types and width helpers for the parameter ROM stream fetcher.
package param_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_FIFO_DEPTH = 4;

    function automatic int cnt_width(input int aw);
        return aw + 1;
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int csum_width(input int dw, input int aw);
        return dw + aw + 1;
    endfunction

endpackage

// File: rtl/param_fetch_fifo.sv
// Synchronous FIFO for captured ROM words (data plus last tag) with occupancy.
module param_fetch_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/param_stream_fetch.sv
// Parameter ROM burst sequencer feeding a valid/ready stream.
// Optional running checksum port under `PARAM_FETCH_CHECKSUM_EN.
module param_stream_fetch
    import param_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ADDR_WIDTH:0]     length,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    input  logic [DATA_WIDTH-1:0]   rom_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic                    m_last
`ifdef PARAM_FETCH_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH+ADDR_WIDTH:0] checksum
`endif
);

    localparam int CW = cnt_width(ADDR_WIDTH);
    localparam int OW = occ_width(FIFO_DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CW-1:0]         len_q, len_d;
    logic [CW-1:0]         issued_q, issued_d;
    logic                  in_flight_q, in_flight_d;
    logic                  last_flight_q, last_flight_d;

    logic                  pop;
    logic                  fifo_empty;
    logic [OW-1:0]         occ;
    logic [DATA_WIDTH:0]   head;
    logic [OW:0]           pending;

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        len_d         = len_q;
        issued_d      = issued_q;
        in_flight_d   = 1'b0;
        last_flight_d = 1'b0;
        pending       = {1'b0, occ} + (OW+1)'(in_flight_q);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    len_d    = length;
                    issued_d = '0;
                    state_d  = (length == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                // Reserve a slot for the read already in flight.
                if (pending < (OW+1)'(FIFO_DEPTH)) begin
                    issued_d    = issued_q + CW'(1);
                    in_flight_d = 1'b1;
                    if (issued_d == len_q) begin
                        last_flight_d = 1'b1;
                        state_d       = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!in_flight_q &&
                    (fifo_empty || (occ == OW'(1) && pop)))
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            in_flight_q   <= 1'b0;
            last_flight_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            len_q         <= len_d;
            issued_q      <= issued_d;
            in_flight_q   <= in_flight_d;
            last_flight_q <= last_flight_d;
        end
    end

    param_fetch_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_flight_q),
        .wdata ({last_flight_q, rom_data}),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .count (occ)
    );

    assign rom_addr = base_q + issued_q[ADDR_WIDTH-1:0];
    assign m_valid  = !fifo_empty;
    assign pop      = m_valid && m_ready;
    assign m_data   = m_valid ? head[DATA_WIDTH-1:0] : '0;
    assign m_last   = m_valid && head[DATA_WIDTH];
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

`ifdef PARAM_FETCH_CHECKSUM_EN
    localparam int SW = csum_width(DATA_WIDTH, ADDR_WIDTH);

    logic [SW-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_IDLE && start)
            checksum_d = '0;
        else if (pop)
            checksum_d = checksum_q +
                {{(SW-DATA_WIDTH){m_data[DATA_WIDTH-1]}}, m_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) checksum_q <= '0;
        else        checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_param_stream_fetch.sv
// Directed bench for param_stream_fetch with a queue-based stream model.
module tb_param_stream_fetch;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int NROM  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
`ifdef PARAM_FETCH_CHECKSUM_EN
    logic [DW+AW:0] checksum;
`endif

    param_stream_fetch #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
`ifdef PARAM_FETCH_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency.
    logic [DW-1:0] rom [NROM];
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    word_t         q[$];
    logic [DW-1:0] xlog[$];
    logic          mb = 1'b0;
    logic          dn = 1'b0;
    int            vecs = 0;
    int            errs = 0;
    int            max_occ = 0;

    logic          hv  [8];
    logic [DW-1:0] hd  [8];
    logic          hl  [8];
    logic          hdn [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        vecs++;
        errs++;
        $display("FAIL %s: timeout, busy=%0b expected idle", name, busy);
    endtask

    // Compare current outputs with the model, then advance it one clock.
    task automatic cycle();
        logic  nd;
        logic  acc;
        word_t w;
        chk("busy", 32'(busy), 32'(mb));
        chk("done", 32'(done), 32'(dn));
        if (q.size() == 0) begin
            chk("m_valid_no_word", 32'(m_valid), 32'd0);
        end else if (m_valid) begin
            chk("m_data", 32'(m_data), 32'(q[0].d));
            chk("m_last", 32'(m_last), 32'(q[0].l));
        end
        if (int'(dut.occ) > max_occ) max_occ = int'(dut.occ);
        nd  = 1'b0;
        acc = start && !mb;
        if (dn) mb = 1'b0;
        if (m_valid && m_ready && q.size() > 0) begin
            xlog.push_back(q[0].d);
            void'(q.pop_front());
            if (q.size() == 0) nd = 1'b1;
        end
        if (acc) begin
            mb = 1'b1;
            if (length == '0) begin
                nd = 1'b1;
            end else begin
                for (int i = 0; i < int'(length); i++) begin
                    w.d = rom[(int'(base_addr) + i) % NROM];
                    w.l = (i == int'(length) - 1);
                    q.push_back(w);
                end
            end
        end
        dn = nd;
        @(negedge clk);
    endtask

    task automatic run_idle(input string name, input int budget);
        int n = 0;
        while ((mb || dn) && n < budget) begin
            cycle();
            n++;
        end
        if (mb || dn) fail_timeout(name);
    endtask

    task automatic start_cmd(input logic [AW-1:0] b, input logic [AW:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_m_valid"},  32'(m_valid),  32'd0);
        chk({tag, "_m_last"},   32'(m_last),   32'd0);
        chk({tag, "_m_data"},   32'(m_data),   32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    endtask

    initial begin
        int n;
        for (int a = 0; a < NROM; a++) rom[a] = '0;

        #2;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: ROM[i] = i-2, ready held high; pin latency and throughput.
        for (int i = 0; i < 4; i++) rom[i] = DW'(i - 2);
        m_ready   = 1'b1;
        base_addr = '0;
        length    = 11'd4;
        start     = 1'b1;
        for (int k = 0; k < 8; k++) begin
            hv[k]  = m_valid;
            hd[k]  = m_data;
            hl[k]  = m_last;
            hdn[k] = done;
            cycle();
            if (k == 0) start = 1'b0;
        end
        chk("t1_valid_c2", 32'(hv[2]), 32'd0);
        chk("t1_valid_c3", 32'(hv[3]), 32'd1);
        chk("t1_valid_c6", 32'(hv[6]), 32'd1);
        chk("t1_data_c3",  32'(hd[3]), 32'hFE);
        chk("t1_data_c4",  32'(hd[4]), 32'hFF);
        chk("t1_data_c5",  32'(hd[5]), 32'h00);
        chk("t1_data_c6",  32'(hd[6]), 32'h01);
        chk("t1_last_c5",  32'(hl[5]), 32'd0);
        chk("t1_last_c6",  32'(hl[6]), 32'd1);
        chk("t1_done_c6",  32'(hdn[6]), 32'd0);
        chk("t1_done_c7",  32'(hdn[7]), 32'd1);
        run_idle("t1_idle", 20);

        // 2: burst wrapping past the top address.
        for (int a = 0; a < NROM; a++) rom[a] = DW'(a * 3 + 1);
        xlog.delete();
        start_cmd(10'd1020, 11'd8);
        run_idle("t2_idle", 50);
        chk("t2_count", 32'(xlog.size()), 32'd8);
        if (xlog.size() == 8) begin
            chk("t2_word0", 32'(xlog[0]), 32'hF5);
            chk("t2_word3", 32'(xlog[3]), 32'hFE);
            chk("t2_word4", 32'(xlog[4]), 32'h01);
        end

        // 3: ready high one cycle in three.
        xlog.delete();
        max_occ = 0;
        start_cmd(10'd100, 11'd16);
        n = 0;
        while ((mb || dn) && n < 300) begin
            m_ready = (n % 3 == 2);
            cycle();
            n++;
        end
        if (mb || dn) fail_timeout("t3_idle");
        m_ready = 1'b1;
        chk("t3_count", 32'(xlog.size()), 32'd16);
        if (xlog.size() == 16)
            chk("t3_word15", 32'(xlog[15]), 32'h5A);
        chk("t3_occ_max", 32'(max_occ), 32'(DEPTH));

        // 4: zero-length command, then start while busy.
        xlog.delete();
        start_cmd(10'd0, 11'd0);
        chk("t4_done_next", 32'(done), 32'd1);
        run_idle("t4a_idle", 10);
        chk("t4_no_words", 32'(xlog.size()), 32'd0);
        start_cmd(10'd0, 11'd4);
        base_addr = 10'd500;
        length    = 11'd9;
        start     = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        start = 1'b0;
        run_idle("t4b_idle", 30);
        chk("t4_count", 32'(xlog.size()), 32'd4);
        if (xlog.size() == 4)
            chk("t4_word0", 32'(xlog[0]), 32'h01);

        // 5: asynchronous reset in the middle of a 10-word burst.
        xlog.delete();
        start_cmd(10'd0, 11'd10);
        n = 0;
        while (xlog.size() < 5 && n < 50) begin
            cycle();
            n++;
        end
        if (xlog.size() < 5) fail_timeout("t5_words");
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("t5_reset");
        q.delete();
        mb = 1'b0;
        dn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        xlog.delete();
        start_cmd(10'd0, 11'd2);
        run_idle("t5_idle", 20);
        chk("t5_count", 32'(xlog.size()), 32'd2);
        if (xlog.size() == 2) begin
            chk("t5_word0", 32'(xlog[0]), 32'h01);
            chk("t5_word1", 32'(xlog[1]), 32'h04);
        end

`ifdef PARAM_FETCH_CHECKSUM_EN
        // 6: checksum of -128, 127, -1.
        rom[0] = 8'h80;
        rom[1] = 8'h7F;
        rom[2] = 8'hFF;
        start_cmd(10'd0, 11'd3);
        n = 0;
        while (!dn && n < 30) begin
            cycle();
            n++;
        end
        if (!dn) fail_timeout("t6_done");
        chk("t6_checksum", 32'(checksum), 32'h7FFFE);
        run_idle("t6_idle", 10);
        chk("t6_checksum_hold", 32'(checksum), 32'h7FFFE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
